inst_mem_sync: RTL and testbench
================================

# inst_mem_sync

Parametrised, synchronous successor to the combinational instruction ROM: a byte-addressed, little-endian instruction memory with a registered valid/ready fetch port and a byte-enable program-load port. It sits between the IF stage and the boot/debug loader. It replaces hard-wired contents with run-time loading and reports misaligned or out-of-range fetches instead of returning undefined data.

## Interface
- ADDR_W, 32, fetch/load address width in bits
- DATA_W, 32, instruction word width; multiple of 8
- DEPTH_BYTES, 1024, memory size in bytes; power of 2, multiple of DATA_W/8
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request
- req_ready  out  1  fetch accepted when req_valid && req_ready
- req_addr  in  ADDR_W  byte address of fetch
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_inst  out  DATA_W  fetched word; byte at address a on lane a mod NB (NB = DATA_W/8)
- rsp_addr  out  ADDR_W  echo of accepted req_addr
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range
- ld_en  in  1  load write strobe
- ld_addr  in  ADDR_W  load byte address; low log2(NB) bits ignored
- ld_data  in  DATA_W  load data, little-endian lanes
- ld_be  in  NB  per-byte write enable
- ld_err  out  1  one-cycle pulse: previous load was out of range and was dropped

## Operation
- Storage: DEPTH_BYTES/NB words × DATA_W bits. Contents are not reset and survive rst_n.
- req_ready = !ld_en && (!rsp_valid || rsp_ready). A load has strict priority over a fetch in the same cycle.
- Accept edge:
  - Register rsp_addr = req_addr and set rsp_valid = 1.
  - Out-of-range check first: req_addr >= DEPTH_BYTES gives rsp_err = 10 and rsp_inst = 0.
  - Else misaligned (req_addr[log2(NB)-1:0] != 0) gives rsp_err = 01 and rsp_inst = 0.
  - Else rsp_err = 00 and rsp_inst = mem[req_addr >> log2(NB)].
- Response hold: while rsp_valid && !rsp_ready, all rsp_* outputs are stable. Loads during the hold never alter the held rsp_inst.
- Response handoff: if the response is consumed and a new request is accepted in the same cycle, the next response replaces it with no bubble. If it is consumed with no new accept, rsp_valid goes to 0.
- Load:
  - When ld_en and ld_addr < DEPTH_BYTES, write the lanes selected by ld_be into word ld_addr >> log2(NB); other lanes are unchanged.
  - When ld_en and the address is out of range, no write occurs and ld_err = 1 in the next cycle.
- Two-state response FSM:
  - EMPTY → FULL on accept.
  - FULL → FULL on consume+accept.
  - FULL → EMPTY on consume without accept.
  - FULL holds when not consumed.

## Timing
- Fetch latency is 1 cycle: accept at edge N, rsp_valid high after edge N.
- Throughput is 1 fetch/cycle when rsp_ready is held high and ld_en is low.
- A load at edge N is visible to a fetch accepted at edge N+1 or later.
- Reset values: rsp_valid 0, rsp_inst 0, rsp_addr 0, rsp_err 00, ld_err 0, FSM EMPTY. req_ready is 1 after reset when ld_en is low.
- Reset asserted mid-response drops the pending response immediately (asynchronous). No memory write occurs while rst_n is low.
- req_addr wrap: no wrap-around. Any address >= DEPTH_BYTES is an error, including addresses that alias modulo DEPTH_BYTES.

## Structure
- Shared defines header holds the error codes (IMEM_ERR_OK/MISALIGN/RANGE) and `InstAddrBus/`InstBus-compatible width macros. Parameters default to those widths.
- One sub-module, inst_mem_bank: NB byte-wide synchronous RAM lanes with a common word address, per-lane write enable, and registered read.
- The top level holds the FSM, the range and alignment checks, and ready logic.

## Test plan
- Load word 0x002081B3 at 0x4 with ld_be = 1111, then fetch 0x4 → rsp_inst 0x002081B3, rsp_err 00, one cycle after accept.
- Load 0xAABBCCDD at 0x8, then load 0x11 at 0x8 with ld_be = 0001; fetch 0x8 → 0xAABBCC11.
- Fetch 0x6 → rsp_err 01, rsp_inst 0. Fetch 0x400 (DEPTH_BYTES = 1024) → rsp_err 10. Load to 0x400 → ld_err pulse and memory unchanged.
- Back-to-back fetches 0x0, 0x4, 0x8 with rsp_ready held low for 3 cycles on the second response:
  - req_ready low during the stall.
  - Responses appear in order with no loss or duplication.
  - rsp_inst is stable while held.
- ld_en and req_valid asserted in the same cycle → req_ready 0, load written, fetch accepted the next cycle and returns the new data.
- Assert rst_n low while rsp_valid = 1 → rsp_valid 0 immediately. Previously loaded words are still returned after release.

Source files
------------

// File: rtl/inst_mem_sync_pkg.sv
// Shared constants and types for the synchronous instruction memory.
package inst_mem_sync_pkg;

  // Widths compatible with the instruction address and data buses.
  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned BYTE_W      = 8;

  // Fetch response error codes.
  localparam logic [1:0] IMEM_ERR_OK       = 2'b00;
  localparam logic [1:0] IMEM_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] IMEM_ERR_RANGE    = 2'b10;

  // Response slot state.
  typedef enum logic {
    StEmpty,
    StFull
  } rsp_state_e;

endpackage

// File: rtl/inst_mem_bank.sv
// Byte-lane RAM bank: NB byte-wide lanes sharing a word address, per-lane write
// enable and a registered read that only updates on a read strobe.
module inst_mem_bank
  import inst_mem_sync_pkg::*;
#(
  parameter int unsigned DATA_W = INST_W,
  parameter int unsigned WORDS  = 256,
  parameter int unsigned WA_W   = $clog2(WORDS)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [WA_W-1:0]            waddr,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       re,
  input  logic [WA_W-1:0]            raddr,
  output logic [DATA_W-1:0]          rdata
);

  localparam int unsigned NB = DATA_W / BYTE_W;

  for (genvar l = 0; l < NB; l++) begin : g_lane
    logic [BYTE_W-1:0] lane_mem [WORDS];
    logic [BYTE_W-1:0] rd_q;

    // Lane write and held read; the read register keeps its value between
    // strobes so a stalled response is immune to later writes.
    always_ff @(posedge clk) begin
      if (we && be[l]) begin
        lane_mem[waddr] <= wdata[BYTE_W*l +: BYTE_W];
      end
      if (re) begin
        rd_q <= lane_mem[raddr];
      end
    end

    assign rdata[BYTE_W*l +: BYTE_W] = rd_q;
  end

endmodule

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory: valid/ready fetch port with one-cycle latency,
// range/alignment error reporting, and a byte-enable program-load port.
module inst_mem_sync
  import inst_mem_sync_pkg::*;
#(
  parameter int unsigned ADDR_W      = INST_ADDR_W,
  parameter int unsigned DATA_W      = INST_W,
  parameter int unsigned DEPTH_BYTES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_inst,
  output logic [ADDR_W-1:0]          rsp_addr,
  output logic [1:0]                 rsp_err,
  input  logic                       ld_en,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic [DATA_W/BYTE_W-1:0]   ld_be,
  output logic                       ld_err
);

  localparam int unsigned NB    = DATA_W / BYTE_W;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned WORDS = DEPTH_BYTES / NB;
  localparam int unsigned WA_W  = $clog2(WORDS);

  // One extra bit so the limit is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(NB - 1);

  rsp_state_e state_q, state_d;

  logic              accept;
  logic              req_range_err;
  logic              req_misalign;
  logic              ld_in_range;
  logic              bank_we;
  logic              bank_re;
  logic [1:0]        err_d;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [1:0]        rsp_err_q;
  logic              inst_ok_q;
  logic              ld_err_q;
  logic [DATA_W-1:0] bank_rdata;

  // No wrap-around: any address at or beyond the memory size is an error.
  assign req_range_err = {1'b0, req_addr} >= ADDR_LIM;
  assign req_misalign  = (req_addr & OFF_MASK) != '0;
  assign ld_in_range   = {1'b0, ld_addr} < ADDR_LIM;

  assign rsp_valid = (state_q == StFull);
  // Loads win over fetches; a full slot only frees up when it is consumed.
  assign req_ready = !ld_en && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  assign bank_we = ld_en && ld_in_range && rst_n;
  assign bank_re = accept && !req_range_err && !req_misalign && rst_n;

  // Error classification of the incoming request; range takes precedence.
  always_comb begin
    err_d = IMEM_ERR_OK;
    if (req_range_err) begin
      err_d = IMEM_ERR_RANGE;
    end else if (req_misalign) begin
      err_d = IMEM_ERR_MISALIGN;
    end
  end

  // Response slot next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) state_d = StFull;
      end
      StFull: begin
        if (accept) begin
          state_d = StFull;
        end else if (rsp_ready) begin
          state_d = StEmpty;
        end
      end
    endcase
  end

  // Response slot, echoed address/error and load-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      rsp_addr_q <= '0;
      rsp_err_q  <= IMEM_ERR_OK;
      inst_ok_q  <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_err_q <= ld_en && !ld_in_range;
      if (accept) begin
        rsp_addr_q <= req_addr;
        rsp_err_q  <= err_d;
        inst_ok_q  <= (err_d == IMEM_ERR_OK);
      end
    end
  end

  inst_mem_bank #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .WA_W   (WA_W)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (ld_addr[OFF_W +: WA_W]),
    .be    (ld_be),
    .wdata (ld_data),
    .re    (bank_re),
    .raddr (req_addr[OFF_W +: WA_W]),
    .rdata (bank_rdata)
  );

  // Errored responses and the post-reset state read as zero, independent of
  // whatever the uninitialised read register holds.
  assign rsp_inst = inst_ok_q ? bank_rdata : '0;
  assign rsp_addr = rsp_addr_q;
  assign rsp_err  = rsp_err_q;
  assign ld_err   = ld_err_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed bench for inst_mem_sync with a byte-level memory model and a
// response scoreboard checked at every consumed response.
module tb_inst_mem_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_err;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;
  logic        ld_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [1:0]  err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [1024];
  logic       exp_valid = 1'b0;
  logic       exp_ld_err = 1'b0;
  logic       hold_pend = 1'b0;
  exp_t       held;

  inst_mem_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_be     (ld_be),
    .ld_err    (ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_fetch(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    if (a >= 32'd1024) begin
      e.err  = 2'b10;
      e.inst = '0;
    end else if (a[1:0] != 2'b00) begin
      e.err  = 2'b01;
      e.inst = '0;
    end else begin
      e.err  = 2'b00;
      e.inst = {mdl[{a[9:2], 2'd3}], mdl[{a[9:2], 2'd2}],
                mdl[{a[9:2], 2'd1}], mdl[{a[9:2], 2'd0}]};
    end
    return e;
  endfunction

  // Monitor: protocol model, hold stability, scoreboard and memory model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_valid  = 1'b0;
      exp_ld_err = 1'b0;
      hold_pend  = 1'b0;
    end else begin
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
      chk("ld_err", 64'(ld_err), 64'(exp_ld_err));
      chk("req_ready", 64'(req_ready), 64'(!ld_en && (!exp_valid || rsp_ready)));
      if (hold_pend) begin
        chk("hold_inst", 64'(rsp_inst), 64'(held.inst));
        chk("hold_addr", 64'(rsp_addr), 64'(held.addr));
        chk("hold_err", 64'(rsp_err), 64'(held.err));
      end
      hold_pend = rsp_valid && !rsp_ready;
      held.inst = rsp_inst;
      held.addr = rsp_addr;
      held.err  = rsp_err;
      if (rsp_valid && rsp_ready) begin
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_inst", 64'(rsp_inst), 64'(e.inst));
          chk("sb_addr", 64'(rsp_addr), 64'(e.addr));
          chk("sb_err", 64'(rsp_err), 64'(e.err));
        end
      end
      if (req_valid && req_ready) begin
        sb.push_back(model_fetch(req_addr));
        exp_valid = 1'b1;
      end else if (exp_valid && rsp_ready) begin
        exp_valid = 1'b0;
      end
      exp_ld_err = ld_en && (ld_addr >= 32'd1024);
      if (ld_en && ld_addr < 32'd1024) begin
        for (int l = 0; l < 4; l++) begin
          if (ld_be[l]) mdl[{ld_addr[9:2], 2'(l)}] = ld_data[8*l +: 8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    ld_be   = be;
    tick();
    ld_en = 1'b0;
    ld_be = '0;
  endtask

  // Returns just after the accepting edge, with the response on the outputs.
  task automatic fetch(input logic [31:0] a);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_accept_bound", 64'(n < 20), 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    ld_be     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_inst", 64'(rsp_inst), 64'd0);
    chk("rst_rsp_addr", 64'(rsp_addr), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_ld_err", 64'(ld_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);

    // Basic load then fetch with one-cycle latency.
    load(32'h0, 32'h0000_0013, 4'hF);
    load(32'h4, 32'h0020_81B3, 4'hF);
    req_valid = 1'b1;
    req_addr  = 32'h4;
    tick();
    req_valid = 1'b0;
    chk("lat_valid", 64'(rsp_valid), 64'd1);
    chk("lat_inst", 64'(rsp_inst), 64'h0020_81B3);
    chk("lat_err", 64'(rsp_err), 64'd0);
    chk("lat_addr", 64'(rsp_addr), 64'h4);
    tick();

    // Partial byte-enable merge.
    load(32'h8, 32'hAABB_CCDD, 4'hF);
    load(32'h8, 32'h0000_0011, 4'h1);
    fetch(32'h8);
    chk("be_merge", 64'(rsp_inst), 64'hAABB_CC11);

    // Error fetches, including an aliasing address.
    fetch(32'h6);
    chk("misalign_err", 64'(rsp_err), 64'd1);
    chk("misalign_inst", 64'(rsp_inst), 64'd0);
    fetch(32'h400);
    chk("range_err", 64'(rsp_err), 64'd2);
    chk("range_inst", 64'(rsp_inst), 64'd0);
    fetch(32'h8000_0000);
    chk("alias_err", 64'(rsp_err), 64'd2);
    fetch(32'h403);
    chk("range_over_misalign", 64'(rsp_err), 64'd2);
    tick();

    // Out-of-range load is dropped and pulses ld_err for one cycle.
    load(32'h400, 32'hDEAD_BEEF, 4'hF);
    chk("ld_err_pulse", 64'(ld_err), 64'd1);
    tick();
    chk("ld_err_clear", 64'(ld_err), 64'd0);
    fetch(32'h0);
    chk("oor_load_no_alias", 64'(rsp_inst), 64'h0000_0013);
    tick();

    // Back-to-back fetches with a three-cycle stall on the second response.
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    req_addr = 32'h4;
    tick();
    rsp_ready = 1'b0;
    req_addr  = 32'h8;
    #1;
    chk("stall_req_ready", 64'(req_ready), 64'd0);
    chk("stall_addr", 64'(rsp_addr), 64'h4);
    tick();
    ld_en   = 1'b1;
    ld_addr = 32'h4;
    ld_data = 32'h5555_5555;
    ld_be   = 4'hF;
    tick();
    ld_en = 1'b0;
    ld_be = '0;
    tick();
    chk("stall_held_inst", 64'(rsp_inst), 64'h0020_81B3);
    chk("stall_held_addr", 64'(rsp_addr), 64'h4);
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("b2b_third_addr", 64'(rsp_addr), 64'h8);
    chk("b2b_third_inst", 64'(rsp_inst), 64'hAABB_CC11);
    tick();
    chk("b2b_drained", 64'(rsp_valid), 64'd0);
    chk("b2b_sb_empty", 64'(sb.size()), 64'd0);

    // Load and fetch in the same cycle: load first, fetch sees new data.
    req_valid = 1'b1;
    req_addr  = 32'hC;
    ld_en     = 1'b1;
    ld_addr   = 32'hC;
    ld_data   = 32'h1234_5678;
    ld_be     = 4'hF;
    #1;
    chk("ld_prio_ready", 64'(req_ready), 64'd0);
    tick();
    ld_en = 1'b0;
    ld_be = '0;
    #1;
    chk("ld_prio_ready_after", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("ld_prio_inst", 64'(rsp_inst), 64'h1234_5678);
    chk("ld_prio_addr", 64'(rsp_addr), 64'hC);
    tick();

    // Reset while a response is pending; memory survives, no write in reset.
    rsp_ready = 1'b0;
    fetch(32'h4);
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    chk("pre_rst_inst", 64'(rsp_inst), 64'h5555_5555);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_valid", 64'(rsp_valid), 64'd0);
    chk("rst_drop_inst", 64'(rsp_inst), 64'd0);
    sb.delete();
    ld_en   = 1'b1;
    ld_addr = 32'h0;
    ld_data = 32'hFFFF_FFFF;
    ld_be   = 4'hF;
    tick();
    ld_en = 1'b0;
    ld_be = '0;
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    fetch(32'h0);
    chk("post_rst_word0", 64'(rsp_inst), 64'h0000_0013);
    fetch(32'h4);
    chk("post_rst_word1", 64'(rsp_inst), 64'h5555_5555);
    tick();
    tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
